// File: rtl/pdu_pkg.sv
// pdu_pkg: shared constants and state encoding for the PDU display path
package pdu_pkg;
  localparam int PDU_DW = 32;
  localparam int PDU_CLK_HZ = 50_000_000;
  localparam int SDB_HOLD_DEFAULT = PDU_CLK_HZ / 2;
  typedef enum logic {SDB_IDLE = 1'b0, SDB_HOLD = 1'b1} sdb_state_t;
endpackage

// File: rtl/seg_data_buffer_if.sv
// seg_data_buffer_if: CPU-side handshake and display-side outputs of the buffer
interface seg_data_buffer_if #(parameter int DW = 32, parameter int DEPTH = 4);
  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   in_ready;
  logic                   flush;
  logic [DW-1:0]          output_data;
  logic                   out_update;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  modport master(output in_valid, in_data, flush, input in_ready, output_data, out_update, count, busy);
  modport slave(input in_valid, in_data, flush, output in_ready, output_data, out_update, count, busy);
endinterface

// File: rtl/seg_fifo.sv
// seg_fifo: synchronous FIFO with comb head output and synchronous clear
module seg_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  assign do_push = push && !full && !clr && !rst;
  assign do_pop = pop && !empty && !clr;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/seg_data_buffer.sv
// seg_data_buffer: queues CPU display values and paces them out at least HOLD_CYCLES apart
module seg_data_buffer
  import pdu_pkg::*;
#(
  parameter int DW = PDU_DW,
  parameter int DEPTH = 4,
  parameter int HOLD_CYCLES = SDB_HOLD_DEFAULT
) (
  input logic clk,
  input logic rst,
  seg_data_buffer_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] RELOAD = HW'(HOLD_CYCLES - 1);
  sdb_state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [DW-1:0] head;
  logic full, empty, push, load;
  assign bus.in_ready = !full && !bus.flush;
  assign push = bus.in_valid && bus.in_ready;
  assign bus.busy = state == SDB_HOLD || !empty;
  // a new value is taken whenever the hold window has expired, so HOLD chains without an IDLE bubble
  assign load = !bus.flush && !empty && (state == SDB_IDLE || hold_cnt == '0);
  always_comb begin
    state_n = bus.flush ? SDB_IDLE : load ? SDB_HOLD : (state == SDB_HOLD && hold_cnt == '0) ? SDB_IDLE : state;
    hold_n = bus.flush ? '0 : load ? RELOAD : hold_cnt != '0 ? hold_cnt - HW'(1) : hold_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SDB_IDLE;
      hold_cnt <= '0;
      bus.output_data <= '0;
      bus.out_update <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      bus.out_update <= load;
      if (load) bus.output_data <= head;
    end
  end
  seg_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(bus.flush),
    .push(push),
    .din(bus.in_data),
    .pop(load),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(bus.count)
  );
endmodule
